// File: rtl/dm_arbiter_if.sv
// One requester port of the data-memory arbiter: request, store data and
// byte address toward the arbiter; load data and completion pulse back.
interface dm_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, width, addr, wdata, input rdata, ack);
  modport slave  (input req, we, width, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter in front of the single-port word-wide data memory.
// Port 0 is the CPU MEM stage, port 1 the loader/DMA. Sub-word stores are
// done as read-modify-write; loads come back zero-extended at bit 0.
//
// state  | meaning
// IDLE   | no transaction; pick a requester and latch its request
// ACCESS | memory addressed; load completes, word store writes,
//        | sub-word store reads the old word
// MERGE  | sub-word store writes the merged word
module dm_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;

  state_t              state;
  logic                last_grant;
  logic                gnt;
  logic                we_q;
  logic [1:0]          width_q;
  logic [1:0]          lane_q;
  logic [15:0]         wdata_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                m0_ack_q, m1_ack_q;
  logic [31:0]         m0_rdata_q, m1_rdata_q;

  logic                pick;
  logic                sel_we;
  logic [1:0]          sel_width;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;

  // Addresses wrap: bits above the word index never reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{m0.addr[31:ADDR_W+2], m1.addr[31:ADDR_W+2]};

  function automatic logic is_word(input logic [1:0] width);
    return (width == 2'b00) || (width == 2'b11);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  width,
                                          input logic [1:0]  lane);
    case (width)
      2'b01:   return lane[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      2'b10:   return {24'b0, w[{lane, 3'b000} +: 8]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0]  width,
                                        input logic [1:0]  lane);
    logic [31:0] r;
    r = old;
    if (width == 2'b01) begin
      if (lane[1]) r[31:16] = d;
      else         r[15:0]  = d;
    end else begin
      r[{lane, 3'b000} +: 8] = d[7:0];
    end
    return r;
  endfunction

  // Both requesting: the port that did not win last time goes next.
  assign pick      = (m0.req && m1.req) ? ~last_grant : m1.req;
  assign sel_we    = pick ? m1.we    : m0.we;
  assign sel_width = pick ? m1.width : m0.width;
  assign sel_addr  = pick ? m1.addr  : m0.addr;
  assign sel_wdata = pick ? m1.wdata : m0.wdata;

  // Arbitration / access sequencing with registered memory and port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      we_q        <= 1'b0;
      width_q     <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (m0.req || m1.req) begin
            gnt         <= pick;
            last_grant  <= pick;
            we_q        <= sel_we;
            width_q     <= sel_width;
            lane_q      <= sel_addr[1:0];
            wdata_q     <= sel_wdata[15:0];
            mem_addr_q  <= sel_addr[ADDR_W+1:2];
            mem_wdata_q <= sel_wdata;
            mem_we_q    <= sel_we && is_word(sel_width);
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (gnt) m1_rdata_q <= extract(mem_rdata, width_q, lane_q);
            else     m0_rdata_q <= extract(mem_rdata, width_q, lane_q);
            m0_ack_q <= ~gnt;
            m1_ack_q <= gnt;
            state    <= IDLE;
          end else if (is_word(width_q)) begin
            m0_ack_q <= ~gnt;
            m1_ack_q <= gnt;
            state    <= IDLE;
          end else begin
            mem_wdata_q <= merge(mem_rdata, wdata_q, width_q, lane_q);
            mem_we_q    <= 1'b1;
            state       <= MERGE;
          end
        end
        MERGE: begin
          m0_ack_q <= ~gnt;
          m1_ack_q <= gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset in the write cycle must keep the pending write out of memory.
  assign mem_we    = mem_we_q & ~reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state != IDLE);
  assign m0.ack    = m0_ack_q;
  assign m1.ack    = m1_ack_q;
  assign m0.rdata  = m0_rdata_q;
  assign m1.rdata  = m1_rdata_q;

endmodule
